// File: rtl/ps2_host_rx_if.sv
// rtl/ps2_host_rx_if.sv - PS/2 line inputs plus byte FIFO read side and status flags
interface ps2_host_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd;
  logic [7:0] dout;
  logic       empty;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  // Host side: drives the PS/2 lines and pops bytes.
  modport master (
    output ps2_clk, ps2_data, rd,
    input  dout, empty, parity_err, frame_err, overflow
  );

  // Receiver side.
  modport slave (
    input  ps2_clk, ps2_data, rd,
    output dout, empty, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_host_rx.sv
// rtl/ps2_host_rx.sv - PS/2 device-to-host frame receiver with glitch filter and byte FIFO
module ps2_host_rx #(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 4096,
  parameter int FIFO_BITS = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  ps2_host_rx_if.slave  bus
);
  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int PW    = FIFO_BITS + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    sync_clk_q, sync_dat_q;
  logic          fclk_q, fclk_d, fdat_q, fdat_d, fclk_prev_q;
  logic [FW-1:0] fcnt_clk_q, fcnt_clk_d, fcnt_dat_q, fcnt_dat_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d, par_ok_q, par_ok_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic fall_edge, bit_in, full, empty_w, do_pop, do_push;

  // Glitch filter: a line value is accepted only after FILTER consecutive differing samples.
  always_comb begin
    fclk_d     = fclk_q;
    fdat_d     = fdat_q;
    fcnt_clk_d = '0;
    fcnt_dat_d = '0;
    if (sync_clk_q[1] != fclk_q) begin
      if (fcnt_clk_q == FW'(FILTER - 1)) fclk_d = sync_clk_q[1];
      else                               fcnt_clk_d = fcnt_clk_q + 1'b1;
    end
    if (sync_dat_q[1] != fdat_q) begin
      if (fcnt_dat_q == FW'(FILTER - 1)) fdat_d = sync_dat_q[1];
      else                               fcnt_dat_d = fcnt_dat_q + 1'b1;
    end
  end

  assign fall_edge = fclk_prev_q & ~fclk_q;
  assign bit_in    = fdat_q;

  // Frame decoder: start, 8 data bits LSB-first, odd parity, stop; inter-edge timeout.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    par_ok_d    = par_ok_q;
    tcnt_d      = tcnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    if (fall_edge) begin
      tcnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d  = DATA;
            bitcnt_d = '0;
            par_d    = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {bit_in, shreg_q[7:1]};
          par_d    = par_q ^ bit_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = (par_q == bit_in);
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!par_ok_q) begin
            perr_d = 1'b1;
          end else if (!bit_in) begin
            ferr_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = shreg_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  assign full    = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign empty_w = (wptr_q == rptr_q);
  assign do_pop  = bus.rd & ~empty_w;
  assign do_push = push_q & (~full | do_pop);

  // FIFO pointers; a push into a full FIFO survives only when a pop frees a slot in the same cycle.
  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    ovf_d  = ovf_q | (push_q & full & ~do_pop);
  end

  // All control state, with asynchronous reset to the idle, empty, lines-high condition.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_clk_q  <= 2'b11;
      sync_dat_q  <= 2'b11;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fcnt_clk_q  <= '0;
      fcnt_dat_q  <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b1;
      par_ok_q    <= 1'b0;
      tcnt_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_clk_q  <= {sync_clk_q[0], bus.ps2_clk};
      sync_dat_q  <= {sync_dat_q[0], bus.ps2_data};
      fclk_q      <= fclk_d;
      fdat_q      <= fdat_d;
      fclk_prev_q <= fclk_q;
      fcnt_clk_q  <= fcnt_clk_d;
      fcnt_dat_q  <= fcnt_dat_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      par_ok_q    <= par_ok_d;
      tcnt_q      <= tcnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wptr_q[PW-2:0]] <= push_data_q;
  end

  assign bus.dout       = empty_w ? 8'h00 : mem_q[rptr_q[PW-2:0]];
  assign bus.empty      = empty_w;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_host_rx.sv
// tb/tb_ps2_host_rx.sv - randomized frame stimulus checked against a byte-queue model of the receiver
module tb_ps2_host_rx;
  logic clk_sys = 1'b0;
  logic reset;

  ps2_host_rx_if bus ();

  ps2_host_rx #(.FILTER(4), .TIMEOUT(4096), .FIFO_BITS(3)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  byte unsigned model_q[$];
  bit  exp_ovf  = 1'b0;
  int  exp_perr = 0, exp_ferr = 0, got_perr = 0, got_ferr = 0;
  bit  check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Per-cycle compare against the model, plus error-pulse counting.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (bus.parity_err) got_perr++;
      if (bus.frame_err)  got_ferr++;
    end
    if (check_en && !reset) begin
      check("empty", bus.empty, model_q.size() == 0);
      if (model_q.size() != 0) check("dout", bus.dout, model_q[0]);
      check("overflow", bus.overflow, exp_ovf);
      check("err_exclusive", bus.parity_err & bus.frame_err, 0);
    end
  end

  task automatic cyc(input int n);
    if (n > 0) repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic model_push(input byte unsigned b);
    if (model_q.size() < 8) model_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop();
    check_en = 1'b0;
    bus.rd = 1'b1;
    cyc(1);
    bus.rd = 1'b0;
    if (model_q.size() != 0) model_q.delete(0);
    check_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit measure, input bit rd_on_push);
    logic [10:0] bits;
    int used;
    int k;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.ps2_data = bits[i];
      cyc(half);
      if (i == 10) check_en = 1'b0;
      bus.ps2_clk = 1'b0;
      used = 0;
      if (i == 10 && measure) begin
        k = 0;
        while (bus.empty && k < 40) begin
          cyc(1);
          k++;
        end
        check("push_latency_window", (k >= 6 && k <= 10), 1);
        used = k;
      end
      if (i == 10 && rd_on_push) begin
        cyc(7);
        bus.rd = 1'b1;
        cyc(1);
        bus.rd = 1'b0;
        used = 8;
        if (model_q.size() != 0) model_q.delete(0);
      end
      cyc(half - used);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    cyc(10);
    if (bad_par)       exp_perr++;
    else if (bad_stop) exp_ferr++;
    else               model_push(b);
    check("parity_err_count", got_perr, exp_perr);
    check("frame_err_count", got_ferr, exp_ferr);
    check_en = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int half);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      bus.ps2_data = bits[i];
      cyc(half);
      bus.ps2_clk = 1'b0;
      cyc(half);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_dout"}, bus.dout, 8'h00);
    check({tag, "_parity_err"}, bus.parity_err, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte unsigned drain_exp[8];
    int kind;
    int half;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd       = 1'b0;
    reset        = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc(2);
    check_en = 1'b1;

    // Single frame, 200-cycle bit period, push latency and pop.
    send_frame(8'h1C, 0, 0, 100, 1, 0);
    check("first_byte", bus.dout, 8'h1C);
    pop();
    check("empty_after_rd", bus.empty, 1);

    // Two frames queued, show-ahead ordering.
    send_frame(8'hF0, 0, 0, 100, 0, 0);
    send_frame(8'h1C, 0, 0, 100, 0, 0);
    check("head_F0", bus.dout, 8'hF0);
    pop();
    check("head_1C", bus.dout, 8'h1C);
    pop();

    // Bad parity, then bad stop bit.
    send_frame(8'h1C, 1, 0, 100, 0, 0);
    check("empty_after_parity_err", bus.empty, 1);
    send_frame(8'h1C, 0, 1, 100, 0, 0);
    check("empty_after_stop_err", bus.empty, 1);

    // Partial frame followed by a long idle clock: timeout discards it.
    send_partial(8'h05, 3, 20);
    cyc(5000);
    exp_ferr++;
    check("timeout_frame_err", got_ferr, exp_ferr);
    send_frame(8'h55, 0, 0, 20, 0, 0);
    check("after_timeout", bus.dout, 8'h55);
    pop();

    // Single-cycle clock glitches while idle, data held low to look like a start bit.
    for (int g = 0; g < 5; g++) begin
      bus.ps2_data = 1'b0;
      bus.ps2_clk  = 1'b0;
      cyc(1);
      bus.ps2_clk  = 1'b1;
      cyc(20);
    end
    bus.ps2_data = 1'b1;
    cyc(20);
    check("glitch_no_perr", got_perr, exp_perr);
    check("glitch_no_ferr", got_ferr, exp_ferr);
    send_frame(8'h3A, 0, 0, 20, 0, 0);
    check("after_glitch", bus.dout, 8'h3A);
    pop();

    // Randomized frames, error injection and pops.
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 5);
      half = $urandom_range(15, 40);
      send_frame(8'($urandom), kind == 0, kind == 1, half, 0, 0);
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        pop();
        cyc($urandom_range(0, 3));
      end
    end

    // Fill past capacity, then pop in the push cycle of the tenth frame.
    check_en = 1'b0;
    reset = 1'b1;
    model_q.delete();
    exp_ovf = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check_en = 1'b1;
    for (int f = 0; f < 9; f++) send_frame(8'(f), 0, 0, 20, 0, 0);
    check("overflow_set", bus.overflow, 1);
    check("full_head", bus.dout, 8'h00);
    send_frame(8'h09, 0, 0, 20, 0, 1);
    drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
    for (int i = 0; i < 8; i++) begin
      check("drain", bus.dout, drain_exp[i]);
      pop();
    end
    check("drained_empty", bus.empty, 1);

    // Reset mid-frame with a non-empty FIFO and sticky overflow.
    send_frame(8'h77, 0, 0, 20, 0, 0);
    send_partial(8'hC3, 4, 20);
    bus.ps2_clk = 1'b0;
    check_en = 1'b0;
    reset = 1'b1;
    model_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    check_en = 1'b1;
    send_frame(8'hA5, 0, 0, 20, 0, 0);
    check("after_reset", bus.dout, 8'hA5);
    pop();
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
